// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes, mux selects.
// Pure constants and one helper, no logic of its own.
package mc_ctrl_pkg;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_JAL      = 4'd8;
  localparam logic [3:0] ST_ALUWB    = 4'd9;
  localparam logic [3:0] ST_BEQ      = 4'd10;
  localparam logic [3:0] ST_TRAP     = 4'd11;

  typedef enum logic [3:0] {
    S_FETCH    = ST_FETCH,
    S_DECODE   = ST_DECODE,
    S_MEMADR   = ST_MEMADR,
    S_MEMREAD  = ST_MEMREAD,
    S_MEMWB    = ST_MEMWB,
    S_MEMWRITE = ST_MEMWRITE,
    S_EXECR    = ST_EXECR,
    S_EXECI    = ST_EXECI,
    S_JAL      = ST_JAL,
    S_ALUWB    = ST_ALUWB,
    S_BEQ      = ST_BEQ,
    S_TRAP     = ST_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from ALUOp and instruction funct fields; combinational, zero latency.
// No handshake: output follows inputs in the same cycle.
module alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  op5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [2:0] ctl;

  always_comb begin
    ctl = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD: ctl = ALUC_ADD;
      ALUOP_SUB: ctl = ALUC_SUB;
      default: begin
        case (funct3)
          // op5 separates R-type sub from I-type addi, whose bit 30 is immediate data
          3'b000:  ctl = (funct7b5 && op5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  ctl = ALUC_SLT;
          3'b110:  ctl = ALUC_OR;
          3'b111:  ctl = ALUC_AND;
          default: ctl = ALUC_ADD;
        endcase
      end
    endcase
  end

  assign alu_control = ALU_CTRL_W'(ctl);

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing RV32I through fetch/decode/execute over a unified memory; lw 5, sw/R/I/jal 4, beq 3 cycles.
// Stalls in FETCH/MEMREAD/MEMWRITE until MemReady; optional WAIT_TIMEOUT abort; ILLEGAL_TRAP_EN adds TRAP state and Illegal.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W    = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int WAIT_TIMEOUT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [1:0]            ImmSrc,
  output logic                  RegWrite,
  output logic                  BusErr
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                  Illegal
`endif
);

  state_t     state, state_nxt;
  logic [1:0] alu_op;
  logic       mem_rdy;
  logic       timeout;

  assign mem_rdy = MEM_HANDSHAKE ? MemReady : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  generate
    if (WAIT_TIMEOUT > 0) begin : g_timeout
      localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
      logic [CNT_W-1:0] stall_cnt;
      logic             mem_wait;

      assign mem_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
      // a completing access on the final allowed cycle is not an abort
      assign timeout  = rst && mem_wait && !mem_rdy && (stall_cnt == CNT_W'(WAIT_TIMEOUT - 1));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             stall_cnt <= '0;
        else if (mem_wait && !mem_rdy && !timeout) stall_cnt <= stall_cnt + CNT_W'(1);
        else                                  stall_cnt <= '0;
      end
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    BusErr    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    ImmSrc    = imm_src_of(opcode);
`ifdef ILLEGAL_TRAP_EN
    Illegal   = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_rdy;
        PCWrite   = mem_rdy;
        if (mem_rdy) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BEQ:       state_nxt = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:      state_nxt = S_TRAP;
`else
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (mem_rdy) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_rdy) state_nxt = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        PCWrite   = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        PCWrite   = zero;
        state_nxt = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        ImmSrc  = IMM_I;
        Illegal = 1'b1;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase
    if (timeout) begin
      BusErr    = 1'b1;
      state_nxt = S_FETCH;
    end
  end

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (opcode[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default instance and a WAIT_TIMEOUT=4 instance share stimulus.
// Expected per-cycle control vectors are queued at drive time and popped once per cycle.
module tb_multicycle_controller;

  typedef logic [17:0] vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, MemReady;

  logic       pcw0, adr0, mr0, mw0, irw0, rw0, be0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic       pcw1, adr1, mr1, mw1, irw1, rw1, be1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] alu1;
`ifdef ILLEGAL_TRAP_EN
  logic       ill0, ill1;
`endif

  vec_t v0, v1;
  vec_t q0[$];
  vec_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .MemReady(MemReady), .PCWrite(pcw0), .AdrSrc(adr0), .MemRead(mr0),
    .MemWrite(mw0), .IRWrite(irw0), .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0),
    .ALUControl(alu0), .ImmSrc(imm0), .RegWrite(rw0), .BusErr(be0)
`ifdef ILLEGAL_TRAP_EN
    , .Illegal(ill0)
`endif
  );

  multicycle_controller #(.WAIT_TIMEOUT(4)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .MemReady(MemReady), .PCWrite(pcw1), .AdrSrc(adr1), .MemRead(mr1),
    .MemWrite(mw1), .IRWrite(irw1), .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1),
    .ALUControl(alu1), .ImmSrc(imm1), .RegWrite(rw1), .BusErr(be1)
`ifdef ILLEGAL_TRAP_EN
    , .Illegal(ill1)
`endif
  );

  assign v0 = {pcw0, adr0, mr0, mw0, irw0, rs0, sa0, sb0, alu0, imm0, rw0, be0};
  assign v1 = {pcw1, adr1, mr1, mw1, irw1, rs1, sa1, sb1, alu1, imm1, rw1, be1};

  function automatic vec_t mk(input logic pcw, adr, mr, mw, irw,
                              input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                              input logic rw, be);
    logic [1:0] imm;
    case (opcode)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    return {pcw, adr, mr, mw, irw, rs, sa, sb, alu, imm, rw, be};
  endfunction

  function automatic vec_t e_fetch(input logic r, input logic be);
    return mk(r, 1'b0, 1'b1, 1'b0, r, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, be);
  endfunction
  function automatic vec_t e_decode();  return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0); endfunction
  function automatic vec_t e_memadr();  return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0); endfunction
  function automatic vec_t e_memread(); return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0); endfunction
  function automatic vec_t e_memwb();   return mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0); endfunction
  function automatic vec_t e_memwrite(input logic be);
    return mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, be);
  endfunction
  function automatic vec_t e_exec(input logic [1:0] sb, input logic [2:0] alu);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, sb, alu, 0, 0);
  endfunction
  function automatic vec_t e_jal();   return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0); endfunction
  function automatic vec_t e_aluwb(); return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0); endfunction
  function automatic vec_t e_beq(input logic z);
    return mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0);
  endfunction

  task automatic push(input vec_t e);
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic push2(input vec_t e0, input vec_t e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic check(input string tag);
    vec_t e0, e1;
    if (q0.size() == 0 || q1.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, got %h/%h required an expectation", tag, v0, v1);
      return;
    end
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    n_checks++;
    assert (v0 === e0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut0: got %h required %h", tag, v0, e0);
    end
    n_checks++;
    assert (v1 === e1) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut1: got %h required %h", tag, v1, e1);
    end
  endtask

  task automatic step(input logic rdy, input string tag);
    MemReady = rdy;
    #1;
    check(tag);
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [2:0] alu);
    int n;
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
    zero     = z;
    push(e_fetch(1'b1, 1'b0));
    push(e_decode());
    case (op)
      7'b0000011: begin push(e_memadr()); push(e_memread()); push(e_memwb()); end
      7'b0100011: begin push(e_memadr()); push(e_memwrite(1'b0)); end
      7'b0110011: begin push(e_exec(2'b00, alu)); push(e_aluwb()); end
      7'b0010011: begin push(e_exec(2'b01, alu)); push(e_aluwb()); end
      7'b1101111: begin push(e_jal()); push(e_aluwb()); end
      7'b1100011: push(e_beq(z));
      default: ;
    endcase
    n = q0.size();
    for (int i = 0; i < n; i++) step(1'b1, tag);
  endtask

  initial begin
    rst      = 1'b0;
    opcode   = 7'b0000000;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    MemReady = 1'b1;
    push(e_fetch(1'b1, 1'b0));
    #1 check("reset");
    @(negedge clk);
    rst = 1'b1;

    run("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000);
    run("r_sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001);
    run("i_add",   7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000);
    run("r_slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101);
    run("r_or",    7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011);
    run("i_and",   7'b0010011, 3'b111, 1'b0, 1'b0, 3'b010);
    run("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000);
    run("beq_z1",  7'b1100011, 3'b000, 1'b0, 1'b1, 3'b001);
    run("beq_z0",  7'b1100011, 3'b000, 1'b0, 1'b0, 3'b001);
    run("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000);

    // sw stalled 3 cycles; on the 4th cycle dut1 would time out but completion wins
    opcode = 7'b0100011;
    push(e_fetch(1'b1, 1'b0)); push(e_decode()); push(e_memadr());
    for (int i = 0; i < 4; i++) push(e_memwrite(1'b0));
    step(1'b1, "sw_stall"); step(1'b1, "sw_stall"); step(1'b1, "sw_stall");
    step(1'b0, "sw_stall"); step(1'b0, "sw_stall"); step(1'b0, "sw_stall");
    step(1'b1, "sw_stall_done");
    run("after_sw_stall", 7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000);

    // asynchronous reset while stalled in MEMREAD
    opcode = 7'b0000011;
    push(e_fetch(1'b1, 1'b0)); push(e_decode()); push(e_memadr()); push(e_memread());
    step(1'b1, "lw_pre_rst"); step(1'b1, "lw_pre_rst"); step(1'b1, "lw_pre_rst");
    step(1'b0, "lw_memread");
    push(e_memread());
    #1 check("lw_memread_hold");
    #1 rst = 1'b0;
    push(e_fetch(1'b0, 1'b0));
    #1 check("async_rst");
    @(negedge clk);
    rst = 1'b1;

    // FETCH stuck: dut1 pulses BusErr on stall cycles 4 and 8, dut0 keeps waiting
    opcode = 7'b0110011;
    funct3 = 3'b000;
    funct7b5 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push2(e_fetch(1'b0, 1'b0), e_fetch(1'b0, (i % 4) == 0));
      step(1'b0, "fetch_timeout");
    end
    run("after_fetch_timeout", 7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000);

    // MEMWRITE stuck: dut1 aborts on the 4th stall and drops MemWrite next cycle
    opcode = 7'b0100011;
    push(e_fetch(1'b1, 1'b0)); push(e_decode()); push(e_memadr());
    step(1'b1, "sw_to"); step(1'b1, "sw_to"); step(1'b1, "sw_to");
    for (int i = 1; i <= 4; i++) begin
      push2(e_memwrite(1'b0), e_memwrite(i == 4));
      step(1'b0, "sw_timeout");
    end
    push2(e_memwrite(1'b0), e_fetch(1'b1, 1'b0));
    step(1'b1, "sw_after_abort");
    rst = 1'b0;
    push(e_fetch(1'b1, 1'b0));
    #1 check("resync_rst");
    @(negedge clk);
    rst = 1'b1;

    // unrecognised opcode
    opcode = 7'b0000000;
    push(e_fetch(1'b1, 1'b0));
    push(e_decode());
`ifdef ILLEGAL_TRAP_EN
    push(18'h0);
    push(18'h0);
`else
    push(e_fetch(1'b1, 1'b0));
    push(e_decode());
`endif
    for (int i = 0; i < 4; i++) step(1'b1, "nop_opcode");
`ifdef ILLEGAL_TRAP_EN
    #1;
    n_checks++;
    assert (ill0 === 1'b1 && ill1 === 1'b1) n_pass++;
    else begin
      n_fail++;
      $error("FAIL illegal: got %b%b required 11", ill0, ill1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised controller for the multi-cycle RV32I core, the successor to the single-cycle control_unit. Sequences each instruction through a Moore FSM over a unified instruction/data memory. Adds a memory ready handshake and an optional wait-timeout. Sits beside the multi-cycle datapath inside the next processor top and drives all datapath enables and mux selects.

Parameters:
ALU_CTRL_W, 3, width of ALUControl (encodings below occupy 3 bits; extra MSBs tied 0)
MEM_HANDSHAKE, 1, 1 = stall on MemReady; 0 = MemReady ignored, treated as 1
WAIT_TIMEOUT, 0, max stall cycles in a memory state before abort; 0 = no timeout

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
MemReady  in  1  memory completed current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction/OldPC register enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
ALUControl  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
RegWrite  out  1  register file write enable
BusErr  out  1  one-cycle pulse on memory timeout abort

Behaviour:
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, ALUWB, BEQ (plus TRAP, see option).
- Reset (rst low, async): state = FETCH, stall counter = 0, BusErr = 0. Outputs take FETCH decode immediately.
- FETCH: AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10. IRWrite=PCWrite=MemReady. Advance to DECODE only when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target).
  - lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; jal -> JAL; beq -> BEQ; other -> FETCH (NOP).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: AdrSrc=1, MemRead=1, ResultSrc=00. -> MEMWB when MemReady.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. -> FETCH when MemReady.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. EXECI: same with ALUSrcB=01. Both -> ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero -> FETCH.
- Funct decode:
  - funct3 000: sub if funct7b5 & opcode[5], else add.
  - 010 slt; 110 or; 111 and; others add.
- ImmSrc is combinational from opcode in every state: sw 01, beq 10, jal 11, else 00.
- All unlisted outputs are 0 in every state. Outputs are pure functions of state/inputs, with no register on the output path.
- Latency: lw 5 cycles, sw/R/I/jal 4, beq 3 (zero-wait memory).
- Timeout (WAIT_TIMEOUT>0):
  - Counter increments each cycle in FETCH/MEMREAD/MEMWRITE with MemReady=0.
  - Counter clears on MemReady=1 or state change.
  - When counter == WAIT_TIMEOUT-1 and MemReady=0: BusErr=1 that cycle and next state = FETCH. MemWrite is never held past abort.
- MemReady=1 on the same cycle the timeout would fire: completion wins, no BusErr.

Optional Feature:
ILLEGAL_TRAP_EN. Defined: an unrecognised opcode in DECODE -> TRAP. TRAP holds all outputs 0 (no PC/reg/mem writes) until reset, and asserts an extra output Illegal=1. Undefined: no TRAP state and no Illegal port; an unrecognised opcode returns to FETCH as NOP.

Decomposition:
Package mc_ctrl_pkg holds:
- state encoding localparams;
- opcode constants;
- ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings.

Sub-module alu_decoder (ALUOp, funct3, funct7b5, opcode[5] -> ALUControl) is combinational and reused from the single-cycle design.

Test Plan:
- Reset mid-MEMREAD: assert rst=0 -> state FETCH, MemRead=1, AdrSrc=0, RegWrite=0 asynchronously.
- lw with MemReady=1 always -> sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5, ResultSrc=01.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR. Same with opcode I-ALU -> 000.
- beq: zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; 3 cycles each.
- sw with MemReady low 3 cycles, WAIT_TIMEOUT=0 -> MemWrite held 4 cycles, then FETCH.
- WAIT_TIMEOUT=4, MemReady stuck 0 in FETCH -> BusErr pulse on 4th stall cycle, then FETCH re-entered with counter 0. Opcode 0000000 -> NOP, or TRAP with Illegal=1 under ILLEGAL_TRAP_EN.
